// File: rtl/rtype_ctrl_sequencer.sv
// Hardwired control sequencer for the phase-1 datapath: fetch, R-type decode and
// T0..T6 control pulse generation for ALU, MUL and DIV instructions.
module rtype_ctrl_sequencer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned REG_SEL_W = 4,
  parameter int unsigned COUNT_W   = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   ir,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                PCout,
  output logic                IncPC,
  output logic                MARin,
  output logic                memRead,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                HIin,
  output logic                LOin,
  output logic [4:0]          alu_op,
  output logic                busy,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [COUNT_W-1:0]  instr_count
);

  localparam int unsigned OP_W   = 5;
  localparam int unsigned OP_LSB = DATA_W - OP_W;
  localparam int unsigned RA_LSB = OP_LSB - REG_SEL_W;
  localparam int unsigned RB_LSB = RA_LSB - REG_SEL_W;
  localparam int unsigned RC_LSB = RB_LSB - REG_SEL_W;

  localparam logic [OP_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR  = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHL = 5'b01000;
  localparam logic [OP_W-1:0] OP_ROR = 5'b01001;
  localparam logic [OP_W-1:0] OP_ROL = 5'b01010;
  localparam logic [OP_W-1:0] OP_MUL = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV = 5'b10000;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T5M  = 4'd7,
    ST_T6   = 4'd8
  } state_e;

  state_e               state_q, state_d;
  logic [OP_W-1:0]      opcode_q;
  logic [REG_SEL_W-1:0] ra_q, rb_q, rc_q;
  logic                 illegal_q;
  logic [COUNT_W-1:0]   count_q;

  logic op_legal_c;
  logic op_muldiv_c;
  logic idx_ok_c;
  logic decode_ok_c;
  logic done_c;
  logic unused_ir_low_c;

  // Bits below rc carry no meaning for R-type instructions.
  assign unused_ir_low_c = ^ir[RC_LSB-1:0];

  // Opcode classification from the latched opcode.
  always_comb begin
    op_legal_c  = 1'b0;
    op_muldiv_c = 1'b0;
    case (opcode_q)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: op_legal_c = 1'b1;
      OP_MUL, OP_DIV: begin
        op_legal_c  = 1'b1;
        op_muldiv_c = 1'b1;
      end
      default: op_legal_c = 1'b0;
    endcase
  end

  // Register index range check only exists when a field can exceed the file.
  if (2 ** REG_SEL_W > NUM_REGS) begin : g_idx_chk
    assign idx_ok_c = (32'(ra_q) < NUM_REGS) &&
                      (32'(rb_q) < NUM_REGS) &&
                      (32'(rc_q) < NUM_REGS);
  end else begin : g_idx_all
    assign idx_ok_c = 1'b1;
  end

  assign decode_ok_c = op_legal_c && idx_ok_c;
  assign done_c      = (state_q == ST_T5) || (state_q == ST_T6);

  // State register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run && !illegal_q) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (mem_ready) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3:   state_d = decode_ok_c ? ST_T4 : ST_IDLE;
      ST_T4:   state_d = op_muldiv_c ? ST_T5M : ST_T5;
      ST_T5:   state_d = run ? ST_T0 : ST_IDLE;
      ST_T5M:  state_d = ST_T6;
      ST_T6:   state_d = run ? ST_T0 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // IR fields are captured on the T2->T3 edge, after the IR load.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
    end else if (state_q == ST_T2) begin
      opcode_q <= ir[OP_LSB +: OP_W];
      ra_q     <= ir[RA_LSB +: REG_SEL_W];
      rb_q     <= ir[RB_LSB +: REG_SEL_W];
      rc_q     <= ir[RC_LSB +: REG_SEL_W];
    end
  end

  // Sticky illegal flag and retired-instruction counter.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if ((state_q == ST_T3) && !decode_ok_c) begin
        illegal_q <= 1'b1;
      end
      if (done_c) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  // Moore output decode.
  always_comb begin
    reg_in     = '0;
    reg_out    = '0;
    PCout      = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    memRead    = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Zhighout   = 1'b0;
    Zlowout    = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    alu_op     = '0;
    instr_done = 1'b0;
    busy       = (state_q != ST_IDLE);
    illegal_op = illegal_q;
    case (state_q)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      ST_T1: begin
        memRead = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        if (decode_ok_c) begin
          reg_out = NUM_REGS'(1) << rb_q;
          Yin     = 1'b1;
        end else begin
          illegal_op = 1'b1;
        end
      end
      ST_T4: begin
        reg_out = NUM_REGS'(1) << rc_q;
        Zin     = 1'b1;
        alu_op  = opcode_q;
      end
      ST_T5: begin
        Zlowout    = 1'b1;
        reg_in     = NUM_REGS'(1) << ra_q;
        instr_done = 1'b1;
      end
      ST_T5M: begin
        Zlowout = 1'b1;
        LOin    = 1'b1;
      end
      ST_T6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_rtype_ctrl_sequencer.sv
// Directed bench for rtype_ctrl_sequencer: per-cycle expected control vectors are
// queued as each instruction is driven and compared as the sequencer steps.
module tb_rtype_ctrl_sequencer;

  localparam int S_IDLE = 0;
  localparam int S_T0   = 1;
  localparam int S_T1   = 2;
  localparam int S_T2   = 3;
  localparam int S_T3   = 4;
  localparam int S_T4   = 5;
  localparam int S_T5   = 6;
  localparam int S_T5M  = 7;
  localparam int S_T6   = 8;

  typedef struct packed {
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic        pc_out, inc_pc, mar_in, mem_read, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, zhigh_out, zlow_out, hi_in, lo_in;
    logic [4:0]  alu_op;
    logic        busy, instr_done, illegal_op;
    logic [15:0] count;
    logic [2:0]  count_w;
  } ctrl_t;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir;

  logic [15:0] reg_in, reg_out;
  logic        PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin;
  logic [4:0]  alu_op;
  logic        busy, instr_done, illegal_op;
  logic [15:0] instr_count;

  // Narrow-counter copy: same stimulus, exposes counter wrap in few retirements.
  logic [15:0] unused_s_reg_in, unused_s_reg_out;
  logic        unused_s_pc, unused_s_inc, unused_s_mar, unused_s_rd, unused_s_mdrin;
  logic        unused_s_mdrout, unused_s_irin, unused_s_y, unused_s_z, unused_s_zh;
  logic        unused_s_zl, unused_s_hi, unused_s_lo, unused_s_busy, unused_s_done;
  logic        unused_s_ill;
  logic [4:0]  unused_s_alu;
  logic [2:0]  s_instr_count;

  rtype_ctrl_sequencer u_dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .reg_in(reg_in), .reg_out(reg_out), .PCout(PCout), .IncPC(IncPC), .MARin(MARin),
    .memRead(memRead), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin),
    .alu_op(alu_op), .busy(busy), .instr_done(instr_done), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  rtype_ctrl_sequencer #(.COUNT_W(3)) u_dut_small (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .reg_in(unused_s_reg_in), .reg_out(unused_s_reg_out), .PCout(unused_s_pc),
    .IncPC(unused_s_inc), .MARin(unused_s_mar), .memRead(unused_s_rd),
    .MDRin(unused_s_mdrin), .MDRout(unused_s_mdrout), .IRin(unused_s_irin),
    .Yin(unused_s_y), .Zin(unused_s_z), .Zhighout(unused_s_zh), .Zlowout(unused_s_zl),
    .HIin(unused_s_hi), .LOin(unused_s_lo), .alu_op(unused_s_alu), .busy(unused_s_busy),
    .instr_done(unused_s_done), .illegal_op(unused_s_ill), .instr_count(s_instr_count)
  );

  always #5 clock = ~clock;

  int    n_assert = 0;
  int    n_fail   = 0;
  int    exp_count = 0;
  logic  sticky_ill = 1'b0;
  ctrl_t exp_q[$];
  string tag_q[$];

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0};
  endfunction

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01111, 5'b10000: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctrl_t model(input int st, input logic [31:0] instr);
    ctrl_t      c;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = instr[31:27];
    ra = instr[26:23];
    rb = instr[22:19];
    rc = instr[18:15];
    c = '0;
    c.count      = 16'(exp_count);
    c.count_w    = 3'(exp_count);
    c.illegal_op = sticky_ill;
    c.busy       = (st != S_IDLE);
    case (st)
      S_T0:  begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; end
      S_T1:  begin c.mem_read = 1'b1; c.mdr_in = 1'b1; end
      S_T2:  begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      S_T3:  begin
        if (op_legal(op)) begin c.reg_out = 16'(1) << rb; c.y_in = 1'b1; end
        else c.illegal_op = 1'b1;
      end
      S_T4:  begin c.reg_out = 16'(1) << rc; c.z_in = 1'b1; c.alu_op = op; end
      S_T5:  begin c.zlow_out = 1'b1; c.reg_in = 16'(1) << ra; c.instr_done = 1'b1; end
      S_T5M: begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
      S_T6:  begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; c.instr_done = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctrl_t observe();
    ctrl_t c;
    c = {reg_in, reg_out, PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin,
         Yin, Zin, Zhighout, Zlowout, HIin, LOin, alu_op, busy, instr_done,
         illegal_op, instr_count, s_instr_count};
    return c;
  endfunction

  task automatic push(input int st, input logic [31:0] instr, input string tag);
    exp_q.push_back(model(st, instr));
    tag_q.push_back(tag);
    if (st == S_T5 || st == S_T6) exp_count++;
    if (st == S_T3 && !op_legal(instr[31:27])) sticky_ill = 1'b1;
  endtask

  task automatic check_now();
    ctrl_t obs, e;
    string tag;
    obs = observe();
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    check_now();
  endtask

  // Drives one instruction from T0; waits = extra T1 cycles with mem_ready low.
  task automatic do_instr(input logic [31:0] instr, input int waits,
                          input bit keep_run, input string name);
    ir  = instr;
    run = 1'b1;
    push(S_T0, instr, {name, "/T0"}); tick();
    if (!keep_run) run = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      push(S_T1, instr, $sformatf("%s/T1.%0d", name, i)); tick();
      mem_ready = (i == waits);
    end
    push(S_T2, instr, {name, "/T2"}); tick();
    push(S_T3, instr, {name, "/T3"}); tick();
    ir = ~instr;
    if (!op_legal(instr[31:27])) begin
      push(S_IDLE, instr, {name, "/idle_after_illegal"}); tick();
      return;
    end
    push(S_T4, instr, {name, "/T4"}); tick();
    if (instr[31:27] == 5'b01111 || instr[31:27] == 5'b10000) begin
      push(S_T5M, instr, {name, "/T5M"}); tick();
      push(S_T6, instr, {name, "/T6"}); tick();
    end else begin
      push(S_T5, instr, {name, "/T5"}); tick();
    end
  endtask

  task automatic apply_clear(input string name);
    clear = 1'b1;
    #1;
    exp_count  = 0;
    sticky_ill = 1'b0;
    push(S_IDLE, 32'h0, name);
    check_now();
    @(posedge clock);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    clear     = 1'b1;
    run       = 1'b0;
    mem_ready = 1'b1;
    ir        = 32'h0;
    #2;
    push(S_IDLE, 32'h0, "reset"); check_now();
    @(posedge clock);
    #1;
    clear = 1'b0;
    push(S_IDLE, 32'h0, "idle_run0"); tick();

    do_instr(32'h1891_8000, 0, 1'b0, "add");
    push(S_IDLE, 32'h0, "add/idle"); tick();

    mem_ready = 1'b0;
    do_instr(32'h1891_8000, 3, 1'b0, "add_wait");
    push(S_IDLE, 32'h0, "add_wait/idle"); tick();

    do_instr(enc(5'b01111, 4'd0, 4'd4, 4'd5), 0, 1'b0, "mul");
    push(S_IDLE, 32'h0, "mul/idle"); tick();
    do_instr(enc(5'b10000, 4'd15, 4'd9, 4'd14), 1, 1'b0, "div");
    push(S_IDLE, 32'h0, "div/idle"); tick();

    do_instr(enc(5'b00011, 4'd1, 4'd2, 4'd3), 0, 1'b1, "b2b_add");
    do_instr(enc(5'b00100, 4'd7, 4'd15, 4'd0), 0, 1'b1, "b2b_sub");
    do_instr(enc(5'b00111, 4'd12, 4'd6, 4'd10), 0, 1'b1, "b2b_shr");
    do_instr(enc(5'b01010, 4'd15, 4'd0, 4'd15), 2, 1'b1, "b2b_rol");
    do_instr(enc(5'b01000, 4'd3, 4'd11, 4'd5), 0, 1'b1, "b2b_shl");
    do_instr(enc(5'b01001, 4'd8, 4'd1, 4'd13), 0, 1'b0, "b2b_ror");
    push(S_IDLE, 32'h0, "b2b/idle"); tick();

    do_instr(enc(5'b11111, 4'd1, 4'd2, 4'd3), 0, 1'b1, "illegal");
    for (int i = 0; i < 3; i++) begin
      push(S_IDLE, 32'h0, $sformatf("illegal/hold%0d", i)); tick();
    end
    run = 1'b0;
    apply_clear("illegal/clear");
    push(S_IDLE, 32'h0, "illegal/released"); check_now();
    do_instr(enc(5'b00101, 4'd9, 4'd4, 4'd2), 0, 1'b0, "and_after_clear");
    push(S_IDLE, 32'h0, "and/idle"); tick();

    ir  = 32'h1891_8000;
    run = 1'b1;
    push(S_T0, ir, "abort/T0"); tick();
    push(S_T1, ir, "abort/T1"); tick();
    push(S_T2, ir, "abort/T2"); tick();
    push(S_T3, ir, "abort/T3"); tick();
    push(S_T4, ir, "abort/T4"); tick();
    run = 1'b0;
    apply_clear("abort/clear_in_T4");
    push(S_IDLE, 32'h0, "abort/after1"); check_now();
    push(S_IDLE, 32'h0, "abort/after2"); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
